// File: rtl/core_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_seq_pkg
//  Description : Shared types and default widths for the program sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_seq_pkg;

    // Sequencer operating states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Default widths: PC, LUT index, program select, cycle counter
    localparam int unsigned D_DEFAULT  = 10;
    localparam int unsigned L_DEFAULT  = 4;
    localparam int unsigned S_DEFAULT  = 2;
    localparam int unsigned CW_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/core_seq_branch_lut.sv
`default_nettype none
// ============================================================================
//  Module      : branch_lut
//  Description : 2^L x D register array holding program start addresses and
//                branch targets/offsets. One synchronous write port, two
//                combinational read ports (reads return the pre-write value).
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_lut
    import core_seq_pkg::*;
#(
    parameter int unsigned D = D_DEFAULT,
    parameter int unsigned L = L_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we_i,
    input  logic [L-1:0] waddr_i,
    input  logic [D-1:0] wdata_i,
    input  logic [L-1:0] start_idx_i,
    output logic [D-1:0] start_addr_o,
    input  logic [L-1:0] br_idx_i,
    output logic [D-1:0] br_val_o
);

    localparam int unsigned N = 1 << L;

    logic [D-1:0] lut_q [N];

    // Table storage: cleared by reset, one entry written per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N); i++) begin
                lut_q[i] <= '0;
            end
        end else if (we_i) begin
            lut_q[waddr_i] <= wdata_i;
        end
    end

    assign start_addr_o = lut_q[start_idx_i];
    assign br_val_o     = lut_q[br_idx_i];

endmodule
`default_nettype wire

// File: rtl/core_seq.sv
`default_nettype none
// ============================================================================
//  Module      : core_seq
//  Description : Program sequencer with req/done handshake, selectable start
//                addresses, stall, absolute/relative branches through a
//                writable LUT and a saturating RUN-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_seq
    import core_seq_pkg::*;
#(
    parameter int unsigned D  = D_DEFAULT,
    parameter int unsigned L  = L_DEFAULT,
    parameter int unsigned S  = S_DEFAULT,
    parameter int unsigned CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [S-1:0]  prog_sel,
    input  logic          stall,
    input  logic          halt,
    input  logic          br_en,
    input  logic          br_rel,
    input  logic [L-1:0]  br_idx,
    input  logic          lut_we,
    input  logic [L-1:0]  lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic [CW-1:0] cycles
);

    seq_state_t    state_q;
    logic [D-1:0]  pc_q;
    logic [D-1:0]  pc_d;
    logic [CW-1:0] cycles_q;
    logic [CW-1:0] cycles_d;
    logic          running_q;
    logic          done_q;

    logic [L-1:0]  w_start_idx;
    logic [D-1:0]  w_start_addr;
    logic [D-1:0]  w_br_val;

    // Program select addresses the low LUT entries
    assign w_start_idx = L'(prog_sel);

    branch_lut #(
        .D (D),
        .L (L)
    ) u_lut (
        .clk          (clk),
        .reset        (reset),
        .we_i         (lut_we),
        .waddr_i      (lut_waddr),
        .wdata_i      (lut_wdata),
        .start_idx_i  (w_start_idx),
        .start_addr_o (w_start_addr),
        .br_idx_i     (br_idx),
        .br_val_o     (w_br_val)
    );

    // Next PC while running: stall and halt hold, otherwise branch or step
    always_comb begin
        pc_d = pc_q;
        if (!stall && !halt) begin
            if (br_en) begin
                pc_d = br_rel ? (pc_q + w_br_val) : w_br_val;
            end else begin
                pc_d = pc_q + D'(1);
            end
        end
    end

    // Saturating increment of the cycle counter
    assign cycles_d = (cycles_q == '1) ? cycles_q : (cycles_q + CW'(1));

    // Sequencer FSM with registered PC, status flags and cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cycles_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        pc_q      <= w_start_addr;
                        cycles_q  <= '0;
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    // Every RUN cycle counts, including the one that leaves RUN
                    cycles_q <= cycles_d;
                    if (!req) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end else if (!stall && halt) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        pc_q <= pc_d;
                    end
                end
                DONE: begin
                    if (!req) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign prog_ctr = pc_q;
    assign running  = running_q;
    assign done     = done_q;
    assign cycles   = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_core_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_seq
//  Description : Scoreboard bench for core_seq. Two instances (16-bit and
//                4-bit cycle counters) share stimulus; a reference model
//                predicts every post-edge output and a monitor compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_seq;

    localparam int D = 10;
    localparam int L = 4;
    localparam int S = 2;
    localparam int PC_MOD = 1 << D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic [S-1:0]  prog_sel = '0;
    logic          stall = 1'b0;
    logic          halt = 1'b0;
    logic          br_en = 1'b0;
    logic          br_rel = 1'b0;
    logic [L-1:0]  br_idx = '0;
    logic          lut_we = 1'b0;
    logic [L-1:0]  lut_waddr = '0;
    logic [D-1:0]  lut_wdata = '0;

    logic [D-1:0]  pc_a, pc_b;
    logic          run_a, run_b, done_a, done_b;
    logic [15:0]   cyc_a;
    logic [3:0]    cyc_b;

    core_seq #(.D(D), .L(L), .S(S), .CW(16)) dut_a (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
        .stall(stall), .halt(halt), .br_en(br_en), .br_rel(br_rel),
        .br_idx(br_idx), .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .prog_ctr(pc_a), .running(run_a),
        .done(done_a), .cycles(cyc_a)
    );

    core_seq #(.D(D), .L(L), .S(S), .CW(4)) dut_b (
        .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
        .stall(stall), .halt(halt), .br_en(br_en), .br_rel(br_rel),
        .br_idx(br_idx), .lut_we(lut_we), .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata), .prog_ctr(pc_b), .running(run_b),
        .done(done_b), .cycles(cyc_b)
    );

    typedef struct {
        int pc;
        bit running;
        bit done;
        int cyc16;
        int cyc4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: 0 = idle, 1 = running, 2 = finished
    int     m_mode;
    int     m_pc;
    longint m_cnt;
    int     m_lut[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_cnt  = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.pc      = m_pc;
        e.running = (m_mode == 1);
        e.done    = (m_mode == 2);
        e.cyc16   = (m_cnt > 65535) ? 65535 : int'(m_cnt);
        e.cyc4    = (m_cnt > 15) ? 15 : int'(m_cnt);
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; model predicts outputs after the next rising edge
    task automatic step(input bit r, input int sel = 0, input bit st = 0,
                        input bit h = 0, input bit be = 0, input bit rel = 0,
                        input int bi = 0, input bit we = 0, input int wa = 0,
                        input int wd = 0);
        int rd_sel, rd_br;
        @(negedge clk);
        reset     = 1'b0;
        req       = r;
        prog_sel  = S'(sel);
        stall     = st;
        halt      = h;
        br_en     = be;
        br_rel    = rel;
        br_idx    = L'(bi);
        lut_we    = we;
        lut_waddr = L'(wa);
        lut_wdata = D'(wd);
        rd_sel = m_lut[sel];
        rd_br  = m_lut[bi];
        case (m_mode)
            0: if (r) begin
                   m_pc   = rd_sel;
                   m_cnt  = 0;
                   m_mode = 1;
               end
            1: begin
                   m_cnt = m_cnt + 1;
                   if (!r)           m_mode = 0;
                   else if (st)      ;
                   else if (h)       m_mode = 2;
                   else if (be)      m_pc = rel ? (m_pc + rd_br) % PC_MOD : rd_br;
                   else              m_pc = (m_pc + 1) % PC_MOD;
               end
            default: if (!r) m_mode = 0;
        endcase
        if (we) m_lut[wa] = wd;
        push_exp();
    endtask

    // Asynchronous reset raised mid-cycle, held across one rising edge
    task automatic reset_mid();
        @(negedge clk);
        model_reset();
        push_exp();
        push_exp();
        reset = 1'b1;
    endtask

    // Monitor: compare after every clock edge or reset assertion
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("prog_ctr", 32'(pc_a), 32'(e.pc));
                chk("running", 32'(run_a), 32'(e.running));
                chk("done", 32'(done_a), 32'(e.done));
                chk("cycles16", 32'(cyc_a), 32'(e.cyc16));
                chk("cycles4", 32'(cyc_b), 32'(e.cyc4));
                chk("prog_ctr_b", 32'(pc_b), 32'(e.pc));
            end
        end
    end

    initial begin
        // Power-on reset
        model_reset();
        push_exp();
        push_exp();
        #1 reset = 1'b1;

        // Load LUT entries while idle
        step(0, .we(1), .wa(1), .wd(40));
        step(0, .we(1), .wa(5), .wd(100));
        step(0, .we(1), .wa(6), .wd(10'h3FC));
        step(0, .we(1), .wa(8), .wd(1023));
        step(0, .we(1), .wa(9), .wd(50));
        step(0, .we(1), .wa(2), .wd(200));

        // Start program 1, three plain steps, branches, wrap, combined hold
        step(1, .sel(1));
        repeat (3) step(1);
        step(1, .be(1), .bi(5));
        step(1, .be(1), .rel(1), .bi(6));
        step(1, .be(1), .bi(8));
        step(1);
        step(1, .st(1), .h(1), .be(1), .bi(5));
        step(1, .be(1), .bi(9));
        step(1, .h(1));
        step(1);
        step(1, .h(1));
        step(0);
        step(0);

        // Long run saturates the 4-bit counter, then abort
        step(1, .sel(1));
        repeat (20) step(1);
        step(0);
        step(0);

        // Asynchronous reset in the middle of a run
        step(1, .sel(0));
        repeat (3) step(1);
        reset_mid();

        // Write to entry 2 in the starting cycle: old value used now
        step(0, .we(1), .wa(2), .wd(200));
        step(1, .sel(2), .we(1), .wa(2), .wd(300));
        step(1);
        step(0);
        step(1, .sel(2));
        step(1);
        step(0);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 99) < 90,
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 12,
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1023)));
            if ($urandom_range(0, 199) == 0) reset_mid();
        end

        step(0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_seq.md
# core_seq

Parametrised program sequencer for the single-cycle core, replacing the bare PC/PC_LUT pair and the hard-wired `done` compare. It adds a 4-phase `req`/`done` handshake, multiple selectable programs, stall support, and a runtime-writable branch LUT. It supports absolute and PC-relative branches, and provides a saturating cycle counter for performance measurement. It sits between the control decoder (which supplies `halt`, `br_en`, `br_rel` and `br_idx`) and `instr_ROM` (which consumes `prog_ctr`).

## Interface
- `D`, 10, program counter width.
- `L`, 4, branch LUT index width; the LUT has 2^L entries of D bits.
- `S`, 2, program-select width; LUT entries 0..2^S-1 double as program start addresses. S ≤ L.
- `CW`, 16, cycle counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  1  start request (4-phase handshake).
- `prog_sel`  in  S  selects the program; sampled when the block leaves IDLE.
- `stall`  in  1  holds the PC for this cycle.
- `halt`  in  1  the instruction at `prog_ctr` is a halt.
- `br_en`  in  1  branch taken this cycle.
- `br_rel`  in  1  1 = PC-relative branch, 0 = absolute branch.
- `br_idx`  in  L  LUT entry used for the branch target or offset.
- `lut_we`  in  1  LUT write enable.
- `lut_waddr`  in  L  LUT write address.
- `lut_wdata`  in  D  LUT write data.
- `prog_ctr`  out  D  current instruction address.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `cycles`  out  CW  RUN-cycle count, saturating.

## Operation
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state.
- IDLE:
  - `prog_ctr` holds its value.
  - When `req`=1: `prog_ctr` ← `lut[prog_sel]`, `cycles` ← 0, next state RUN.
- RUN, priority order per cycle:
  1. `req`=0 → abort to IDLE; `done` stays 0 and `prog_ctr` holds.
  2. `stall`=1 → PC holds; `halt` and `br_en` are ignored.
  3. `halt`=1 → DONE; PC holds at the halt address.
  4. `br_en`=1 → PC ← `br_rel` ? `prog_ctr` + `lut[br_idx]` : `lut[br_idx]`.
  5. Otherwise → PC ← `prog_ctr` + 1.
- Arithmetic:
  - All PC arithmetic is modulo 2^D, so 2^D-1 + 1 wraps to 0.
  - For relative branches the LUT entry is a D-bit two's-complement offset.
- `cycles` increments on every RUN cycle, including stalled cycles, and saturates at 2^CW-1. It holds in IDLE and DONE.
- DONE:
  - `done`=1 and `cycles` is frozen.
  - When `req` falls → IDLE.
  - A new run needs `req` to go low and then high again.
- LUT write:
  - Synchronous and accepted in any state.
  - A same-cycle read of the entry being written returns the old value.
  - Applies to both read ports: `prog_sel` at start and `br_idx` during a branch.
- Reset:
  - Asynchronous, effective immediately including mid-run.
  - State → IDLE; `prog_ctr`, `running`, `done` and `cycles` → 0.
  - All LUT entries → 0.

## Timing
- Start latency: `req` sampled high in IDLE → the next edge gives `running`=1 and `prog_ctr` = start address.
- Branch, step and halt decisions use same-cycle combinational inputs. The result is visible on `prog_ctr` or the state one edge later.
- Halt → `done` high on the next edge. `done` → IDLE one edge after `req` is sampled low.
- Abort: `req` sampled low in RUN → IDLE on the next edge.

## Structure
- Package `core_seq_pkg` holds:
  - The state enum `seq_state_t` (IDLE, RUN, DONE).
  - Default width constants for D, L, S and CW.
- Sub-module `branch_lut`:
  - 2^L × D register array with async reset.
  - One synchronous write port.
  - Two combinational read ports: start address and branch target.
- `core_seq` contains the FSM, the PC next-state mux and the cycle counter.

## Test plan
- Reset, write `lut[1]`=40, `prog_sel`=1, raise `req` → `prog_ctr` = 40 with `running` next edge; it reaches 43 after 3 unstalled cycles.
- `lut[5]`=100, absolute branch with `br_idx`=5 at PC 43 → PC 100. `lut[6]`=-4 (0x3FC), relative branch at PC 100 → PC 96.
- PC 1023 with no branch → PC 0. `stall`, `halt` and `br_en` asserted together → PC and state unchanged.
- `halt` at PC 50 → `done`=1 next edge with `prog_ctr`=50 and `cycles` frozen. Drop `req` → IDLE, `done`=0 next edge.
- CW=4, run 20 cycles → `cycles` = 15. `req` dropped mid-run → IDLE with `done` never asserted. Async `reset` mid-run → all outputs 0 immediately.
- `lut_we` to entry 2 in the same cycle `req` starts with `prog_sel`=2 → PC gets the old entry value, and the new value applies on the next run.
